// File: rtl/xor_serial_arbiter.sv
// Round-robin arbiter that shares one external 1-bit XOR gate among NUM_REQ requesters.
// Operands are serialised LSB-first; optional gate self-check enabled by XOR_SERIAL_SELFCHECK_EN.
module xor_serial_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQ-1:0]                          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]                    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]                    req_b,
    output logic [NUM_REQ-1:0]                          req_ready,
    output logic                                        resp_valid,
    input  logic                                        resp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] resp_id,
    output logic [WIDTH-1:0]                            resp_data,
    output logic                                        xor_A,
    output logic                                        xor_B,
    input  logic                                        xor_O,
    output logic                                        err
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [WIDTH-1:0]    res_sh;
    logic [WIDTH-1:0]    res_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic                accept;
    logic                resp_hs;
    logic                last_bit;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // First valid requester at or after ptr, searching upward with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_add(ptr, k)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_add(ptr, k);
                grant_oh[wrap_add(ptr, k)] = 1'b1;
            end
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and a producer holds its payload until the transfer.
    assign accept   = (state == IDLE) && grant_found;
    assign resp_hs  = (state == DONE) && resp_ready;
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    if (resp_hs)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        xor_A      = 1'b0;
        xor_B      = 1'b0;
        case (state)
            IDLE:  req_ready = grant_oh;
            SHIFT: begin
                xor_A = a_sh[0];
                xor_B = b_sh[0];
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_data  = res_sh;
            end
            default: ;
        endcase
    end

    assign resp_id = id_q;

    // Result enters at the MSB so the first (LSB) bit ends up at bit 0 after WIDTH shifts.
    always_comb begin
        res_nxt            = res_sh >> 1;
        res_nxt[WIDTH-1]   = xor_O;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            bit_cnt <= '0;
            id_q    <= '0;
            ptr     <= '0;
        end else begin
            if (accept) begin
                a_sh    <= req_a[grant_id*WIDTH +: WIDTH];
                b_sh    <= req_b[grant_id*WIDTH +: WIDTH];
                res_sh  <= '0;
                id_q    <= grant_id;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                res_sh  <= res_nxt;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (resp_hs) begin
                ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

`ifdef XOR_SERIAL_SELFCHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state == SHIFT) && (xor_O != (a_sh[0] ^ b_sh[0]))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/xor_serial_arbiter.md
# xor_serial_arbiter

Round-robin controller that shares one 1-bit `xorGate` instance among `NUM_REQ` requesters. Each requester submits a pair of `WIDTH`-bit operands. The block serialises the operands LSB-first through the shared gate, one bit per clock, and reassembles the result. It sits between the requester logic and the single `xorGate` instance; the gate itself stays external and purely combinational.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥1.
- `WIDTH`, default 8: operand width in bits, ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand B; same packing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  clog2(NUM_REQ), min 1  index of the requester that owns the result.
- `resp_data`  out  WIDTH  `a ^ b` result.
- `xor_A`  out  1  drives the gate's `A` input.
- `xor_B`  out  1  drives the gate's `B` input.
- `xor_O`  in  1  the gate's `O` output.
- `err`  out  1  sticky self-check error; see Configuration.

## Operation
- States: `IDLE`, `SHIFT`, `DONE`.
- **IDLE:**
  - Grant goes to the first asserted `req_valid` at or after `ptr`, searching upward with wrap.
  - `req_ready` = one-hot grant, combinational, asserted only in IDLE.
  - On `req_valid[i] & req_ready[i]`: latch `req_a[i]` and `req_b[i]` into shift registers `a_sh`/`b_sh`, latch `resp_id=i`, clear `bit_cnt`, go to SHIFT.
  - No valid requests: stay in IDLE.
- **SHIFT:**
  - `xor_A=a_sh[0]`, `xor_B=b_sh[0]`.
  - Each edge: `res_sh <= {xor_O, res_sh[WIDTH-1:1]}`; shift `a_sh`/`b_sh` right by 1; `bit_cnt++`.
  - When `bit_cnt==WIDTH-1` at the edge, go to DONE.
- **DONE:**
  - `resp_valid=1`, `resp_data=res_sh`, all held stable until `resp_ready`.
  - On `resp_valid & resp_ready`: `ptr <= (resp_id==NUM_REQ-1) ? 0 : resp_id+1`; go to IDLE.
- `xor_A`/`xor_B` = 0 outside SHIFT.
- `bit_cnt` width: clog2(WIDTH), min 1. With `WIDTH=1`, SHIFT lasts exactly one cycle.
- Requesters hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted.
- A requester may drop `req_valid` before it is granted; it is then simply skipped.
- `NUM_REQ=1`: the grant is always requester 0 and `ptr` stays 0.

## Timing
- Reset values (async, immediate): state=IDLE, `ptr=0`, `req_ready=0` (no valid input), `resp_valid=0`, `resp_id=0`, `resp_data=0`, `xor_A=0`, `xor_B=0`, `err=0`.
- Accept in cycle 0 → SHIFT in cycles 1..WIDTH → `resp_valid` rises in cycle WIDTH+1.
- Back-to-back throughput with `resp_ready` held high: one result per WIDTH+2 cycles.
- Earliest next accept: the cycle after the response handshake. `req_ready` and `resp_valid` are never high in the same cycle.
- Requests that arrive during SHIFT or DONE wait; they are arbitrated on return to IDLE using the updated `ptr`.
- Reset asserted mid-operation: the in-flight operation is discarded and no response is produced. `ptr` returns to 0.
- `xor_O` is sampled in the same cycle `xor_A`/`xor_B` are driven. The gate is combinational, so there are zero wait states.

## Configuration
- Macro: `XOR_SERIAL_SELFCHECK_EN`.
- **Defined:**
  - Each SHIFT edge compares `xor_O` with `a_sh[0]^b_sh[0]`.
  - A mismatch sets `err` to 1 from the next cycle onward.
  - `err` is cleared only by `rst_n`. It does not affect sequencing.
- **Undefined:**
  - Comparator logic is removed.
  - The `err` port remains and is tied to 0.

## Test plan
- Single request: `NUM_REQ=4`, `WIDTH=8`, `req_valid=4'b0010`, `a=8'hA5`, `b=8'h0F`.
  - Required: `req_ready=4'b0010` in cycle 0.
  - Required: `resp_valid` in cycle 9 with `resp_data=8'hAA`, `resp_id=1`.
- Fairness: all four valid continuously, `resp_ready=1`.
  - Required: grants in order 0,1,2,3,0, with consecutive grants 10 cycles apart.
- Backpressure: hold `resp_ready=0` for 5 cycles in DONE.
  - Required: `resp_valid`, `resp_data` and `resp_id` stable throughout; no `req_ready` while DONE.
  - Required: return to IDLE one cycle after `resp_ready=1`.
- Pointer wrap: only requester 3 completes, then requesters 0 and 2 become valid.
  - Required: requester 0 is granted first.
- Mid-operation reset: drop `rst_n` at SHIFT bit 3.
  - Required: all outputs immediately take their reset values and no `resp_valid` follows.
  - Required: the next accepted request yields its correct result.
- Self-check, `XOR_SERIAL_SELFCHECK_EN` defined: force `xor_O` to 0 during one SHIFT bit where `a^b=1`.
  - Required: `err` goes to 1 on the next cycle and stays 1 until reset.
  - Required: with the macro undefined, `err` stays 0.
